// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: fetch FSM states, the IF/ID payload struct,
// and instruction constants.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID output register with valid/ready handshake and flush.
// The register is free when empty or when its current entry transfers.
// Priority: flush > load > drain-on-transfer > hold.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_ready,
  output logic        o_valid,
  output logic        o_free,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic  valid_q, valid_d;
  ifid_t data_q, data_d;

  assign o_free  = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_pc    = data_q.pc;
  assign o_instr = data_q.instr;

  // Next-state for the entry: flush clears, load captures, a transfer with no
  // replacement empties, otherwise the entry is held for decode.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d      = 1'b1;
      data_d.pc    = i_pc;
      data_d.instr = i_instr;
    end else if (o_free) begin
      valid_d = 1'b0;
    end
  end

  // Register update with synchronous reset to an empty NOP entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q      <= 1'b0;
      data_q.pc    <= '0;
      data_q.instr <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, next-PC, redirect and fault handling in front
// of a combinational-read instruction memory. The IF/ID register lives in
// ifid_reg. Optional macro FETCH_PERF_EN adds transfer/flush counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 13
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_rdata,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [31:0]        o_instr,
  output logic [31:0]        o_pc,
  output logic               o_fault,
  output logic [31:0]        o_fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_flush_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic run;
  logic redir;
  logic free;
  logic pc_bad;
  logic take_fault;
  logic load;

  assign o_imem_addr = pc_q[IMEM_AW-1:0];
  assign o_fault     = fault_q;
  assign o_fault_pc  = fault_pc_q;

  assign run        = (state_q == RUN);
  assign redir      = run && i_redirect_valid;
  assign pc_bad     = (pc_q[1:0] != 2'b00) || (pc_q[31:IMEM_AW] != '0);
  assign take_fault = run && !redir && free && pc_bad;
  assign load       = run && !redir && free && !pc_bad;

  ifid_reg u_ifid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (load),
    .i_flush (redir),
    .i_pc    (pc_q),
    .i_instr (i_imem_rdata),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_free  (free),
    .o_pc    (o_pc),
    .o_instr (o_instr)
  );

  // Next PC and fault capture; a redirect always pre-empts the fault check.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redir) begin
      pc_d = i_redirect_pc;
    end else if (take_fault) begin
      state_d    = HALT;
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end else if (load) begin
      pc_d = pc_q + INSTR_BYTES;
    end
  end

  // PC / FSM / fault state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

  // Count transfers and discarded valid entries; frozen once halted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (run) begin
      if (o_valid && i_ready) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redir && o_valid && !i_ready) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations plus randomized redirect/stall/reset traffic checked every
// cycle against a transaction-level reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        ready;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] opc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  logic [31:0] mem [0:2047];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_opc, m_instr, m_fpc, m_fcnt, m_flcnt;
  bit          m_valid, m_halt;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[12:2]];

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(13)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .i_ready          (ready),
    .o_valid          (valid),
    .o_instr          (instr),
    .o_pc             (opc),
    .o_fault          (fault),
    .o_fault_pc       (fault_pc)
`ifdef FETCH_PERF_EN
    ,
    .o_fetch_cnt      (fetch_cnt),
    .o_flush_cnt      (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  // One clock of the architectural rules, applied to the inputs of this cycle.
  task automatic model_step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit xfer, is_free, badpc;
    if (r) begin
      m_pc = 32'h0; m_valid = 0; m_opc = 32'h0; m_instr = 32'h13;
      m_halt = 0; m_fpc = 32'h0; m_fcnt = 0; m_flcnt = 0;
      return;
    end
    if (m_halt) return;
    xfer    = m_valid && rdy;
    is_free = !m_valid || rdy;
    if (xfer) m_fcnt++;
    if (rv) begin
      if (m_valid && !rdy) m_flcnt++;
      m_pc    = rpc;
      m_valid = 0;
    end else if (is_free) begin
      badpc = (m_pc % 4 != 0) || (m_pc >= 32'h2000);
      if (badpc) begin
        m_halt  = 1;
        m_fpc   = m_pc;
        m_valid = 0;
      end else begin
        m_opc   = m_pc;
        m_instr = mem[m_pc / 4];
        m_valid = 1;
        m_pc    = m_pc + 4;
      end
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    rst = r; redir_v = rv; redir_pc = rpc; ready = rdy;
    @(posedge clk);
    model_step(r, rv, rpc, rdy);
    #1;
    check("valid", {31'b0, valid}, {31'b0, m_valid});
    check("o_pc", opc, m_opc);
    check("o_instr", instr, m_instr);
    check("fault", {31'b0, fault}, {31'b0, m_halt});
    check("fault_pc", fault_pc, m_fpc);
    check("imem_addr", {19'b0, imem_addr}, {19'b0, m_pc[12:0]});
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fcnt);
    check("flush_cnt", flush_cnt, m_flcnt);
`endif
  endtask

  initial begin
    logic [31:0] last_pc;
    logic [31:0] tgt;
    int unsigned p;

    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[0] = 32'hA0A0_0000; mem[1] = 32'hA1A1_0001;
    mem[2] = 32'hA2A2_0002; mem[3] = 32'hA3A3_0003;
    rst = 1; redir_v = 0; redir_pc = 0; ready = 0;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", opc, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);

    // Back-to-back fetch from RESET_PC
    cyc(0, 0, 0, 1); check("seq0_pc", opc, 32'h0); check("seq0_in", instr, 32'hA0A0_0000);
    cyc(0, 0, 0, 1); check("seq1_pc", opc, 32'h4); check("seq1_in", instr, 32'hA1A1_0001);
    cyc(0, 0, 0, 1); check("seq2_pc", opc, 32'h8); check("seq2_in", instr, 32'hA2A2_0002);
    cyc(0, 0, 0, 1); check("seq3_pc", opc, 32'hC); check("seq3_in", instr, 32'hA3A3_0003);

    // Stall while o_pc=4
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      check("stall_pc", opc, 32'h4);
      check("stall_in", instr, 32'hA1A1_0001);
      check("stall_addr", {19'b0, imem_addr}, 32'h8);
    end
    cyc(0, 0, 0, 1); check("unstall_pc", opc, 32'h8);

    // Redirect under back-pressure flushes the held entry
    cyc(0, 1, 32'h40, 0); check("flush_valid", {31'b0, valid}, 32'h0);
    cyc(0, 0, 0, 1);
    check("tgt_valid", {31'b0, valid}, 32'h1);
    check("tgt_pc", opc, 32'h40);
`ifdef FETCH_PERF_EN
    check("flush_cnt1", flush_cnt, 32'h1);
`endif

    // Misaligned redirect faults; later redirects ignored
    cyc(0, 1, 32'h42, 1);
    cyc(0, 0, 0, 1);
    check("mis_fault", {31'b0, fault}, 32'h1);
    check("mis_fpc", fault_pc, 32'h42);
    check("mis_valid", {31'b0, valid}, 32'h0);
    cyc(0, 1, 32'h0, 1);
    cyc(0, 0, 0, 1);
    check("halt_addr", {19'b0, imem_addr}, 32'h42);
    check("halt_valid", {31'b0, valid}, 32'h0);

    // Run off the end of instruction memory
    cyc(1, 0, 0, 1);
    last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 2052; i++) begin
      cyc(0, 0, 0, 1);
      if (valid) last_pc = opc;
    end
    check("oor_fault", {31'b0, fault}, 32'h1);
    check("oor_fpc", fault_pc, 32'h2000);
    check("oor_last", last_pc, 32'h1FFC);

    // Reset mid-stream with a valid entry
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("mid_valid", {31'b0, valid}, 32'h0);
    check("mid_fault", {31'b0, fault}, 32'h0);
    check("mid_addr", {19'b0, imem_addr}, 32'h0);
    cyc(0, 0, 0, 1);
    check("mid_resume", opc, 32'h0);

    // Randomized redirect / stall / reset traffic
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(99);
      if (p < 8) begin
        tgt = {19'b0, 11'($urandom), 2'b00};
        if ($urandom_range(9) == 0) tgt = $urandom;
        cyc(0, 1, tgt, ($urandom_range(9) < 7));
      end else if ((p < 10) || (m_halt && p < 30)) begin
        cyc(1, 0, 0, ($urandom_range(9) < 7));
      end else begin
        cyc(0, ($urandom_range(99) == 0), $urandom, ($urandom_range(9) < 7));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
